// File: rtl/sec_stopwatch.sv
// MM:SS BCD stopwatch advanced by rising edges of a slow level, with IDLE/RUN/PAUSE control
// and a seven-segment decode of the seconds units digit.
module sec_stopwatch #(
   parameter int unsigned MAX_MIN        = 59,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       speed_clock,
   input  logic       reset,
   input  logic       low_clock,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [3:0] sec_units,
   output logic [2:0] sec_tens,
   output logic [3:0] min_units,
   output logic [2:0] min_tens,
   output logic       running,
   output logic       rollover,
   output logic [6:0] hex0
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [2:0] MAX_MT = 3'(MAX_MIN / 10);
   localparam logic [3:0] MAX_MU = 4'(MAX_MIN % 10);

   // Segment pattern {g,f,e,d,c,b,a}, active-high; non-BCD codes blank the display.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   state_t     state_q, state_d;
   logic       lc_prev_q, lc_prev_d;
   logic [3:0] su_q, su_d;
   logic [2:0] st_q, st_d;
   logic [3:0] mu_q, mu_d;
   logic [2:0] mt_q, mt_d;
   logic       running_q, running_d;
   logic       rollover_q, rollover_d;
   logic       tick_s;
   logic       count_s;
   logic       at_max_s;

   assign tick_s   = low_clock & ~lc_prev_q;
   assign count_s  = (state_q == RUN) && tick_s;
   assign at_max_s = (mt_q == MAX_MT) && (mu_q == MAX_MU) && (st_q == 3'd5) && (su_q == 4'd9);

   // Next-state decode: clear beats stop beats start; start+stop together is ignored.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !stop) state_d = RUN;
               else                state_d = IDLE;
            end
            RUN: begin
               if (stop) state_d = PAUSE;
               else      state_d = RUN;
            end
            PAUSE: begin
               if (start && !stop) state_d = RUN;
               else                state_d = PAUSE;
            end
            default: state_d = IDLE;
         endcase
      end
      running_d = (state_d == RUN);
   end

   // BCD counter with cascaded carries; a tick coinciding with clear is dropped.
   always_comb begin
      lc_prev_d  = low_clock;
      su_d       = su_q;
      st_d       = st_q;
      mu_d       = mu_q;
      mt_d       = mt_q;
      rollover_d = 1'b0;
      if (clear) begin
         su_d = 4'd0;
         st_d = 3'd0;
         mu_d = 4'd0;
         mt_d = 3'd0;
      end else if (count_s) begin
         if (at_max_s) begin
            su_d       = 4'd0;
            st_d       = 3'd0;
            mu_d       = 4'd0;
            mt_d       = 3'd0;
            rollover_d = 1'b1;
         end else if (su_q != 4'd9) begin
            su_d = su_q + 4'd1;
         end else begin
            su_d = 4'd0;
            if (st_q != 3'd5) begin
               st_d = st_q + 3'd1;
            end else begin
               st_d = 3'd0;
               if (mu_q != 4'd9) begin
                  mu_d = mu_q + 4'd1;
               end else begin
                  mu_d = 4'd0;
                  // MAX_MIN <= 59 guarantees the wrap above fires before tens passes 5
                  if (mt_q != 3'd5) mt_d = mt_q + 3'd1;
                  else              mt_d = 3'd0;
               end
            end
         end
      end else begin
         rollover_d = 1'b0;
      end
   end

   // State and count registers; the edge detector resets high so a held-high input is not a tick.
   always_ff @(posedge speed_clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         lc_prev_q  <= 1'b1;
         su_q       <= 4'd0;
         st_q       <= 3'd0;
         mu_q       <= 4'd0;
         mt_q       <= 3'd0;
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lc_prev_q  <= lc_prev_d;
         su_q       <= su_d;
         st_q       <= st_d;
         mu_q       <= mu_d;
         mt_q       <= mt_d;
         running_q  <= running_d;
         rollover_q <= rollover_d;
      end
   end

   assign sec_units = su_q;
   assign sec_tens  = st_q;
   assign min_units = mu_q;
   assign min_tens  = mt_q;
   assign running   = running_q;
   assign rollover  = rollover_q;
   assign hex0      = SEG_ACTIVE_LOW ? ~seg_decode(su_q) : seg_decode(su_q);

endmodule
